// File: rtl/moore_seq_detector.sv
// Configurable Moore serial pattern detector with run-time pattern/length and overlap mode.
// Optional saturating match counter is built only when MOORE_DET_CNT_EN is defined.
module moore_seq_detector #(
   parameter int             N        = 6,
   parameter logic [N-1:0]   PAT_INIT = N'(6'b101101),
   parameter int             CNT_W    = 8
) (
   input  logic                     cl,
   input  logic                     r,
   input  logic                     en,
   input  logic                     j,
   input  logic                     ovl,
   input  logic                     pat_ld,
   input  logic [N-1:0]             pat_in,
   input  logic [$clog2(N+1)-1:0]   len_in,
   input  logic                     cnt_clr,
   output logic                     w,
   output logic [$clog2(N+1)-1:0]   prog,
   output logic [CNT_W-1:0]         match_cnt
);

   localparam int LW = $clog2(N+1);

   logic [N-1:0]  pat_q, nxt_pat;
   logic [LW-1:0] len_q, nxt_len;
   logic [N-1:0]  hist_q, nxt_hist;
   logic [LW-1:0] prog_q, nxt_prog;
   logic [LW-1:0] step_val;
   logic          enter_match;
   logic          unused_ok;

   function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
      if (l == '0)
         return LW'(1);
      else if (int'(l) > N)
         return LW'(N);
      else
         return l;
   endfunction

   // Longest pattern prefix (<= len) ending the stream {hist, jb}. Only the last
   // cur bits of history are trusted, which keeps restarts and loads exact.
   function automatic logic [LW-1:0] step_prog(input logic [N-1:0]  pat,
                                                input logic [N-2:0]  hist,
                                                input logic [LW-1:0] len,
                                                input logic [LW-1:0] cur,
                                                input logic          jb);
      logic [N-1:0] s;
      logic         ok;
      int           best;
      s    = {hist, jb};
      best = 0;
      for (int k = 1; k <= N; k++) begin
         if (k <= int'(len) && (k - 1) <= int'(cur)) begin
            ok = 1'b1;
            for (int t = 0; t < k; t++)
               if (pat[t] != s[k-1-t]) ok = 1'b0;
            if (ok) best = k;
         end
      end
      return LW'(best);
   endfunction

   assign step_val = (prog_q == len_q && !ovl) ? ((j == pat_q[0]) ? LW'(1) : LW'(0))
                                                : step_prog(pat_q, hist_q[N-2:0], len_q, prog_q, j);
   assign enter_match = en && !pat_ld && (step_val == len_q);

   always_ff @(posedge cl) begin
      if (r) begin
         pat_q  <= PAT_INIT;
         len_q  <= LW'(N);
         hist_q <= '0;
         prog_q <= '0;
      end else begin
         pat_q  <= nxt_pat;
         len_q  <= nxt_len;
         hist_q <= nxt_hist;
         prog_q <= nxt_prog;
      end
   end

   always_comb begin
      nxt_pat  = pat_q;
      nxt_len  = len_q;
      nxt_hist = hist_q;
      nxt_prog = prog_q;
      if (pat_ld) begin
         nxt_pat  = pat_in;
         nxt_len  = clamp_len(len_in);
         nxt_hist = '0;
         nxt_prog = '0;
      end else if (en) begin
         nxt_hist = {hist_q[N-2:0], j};
         nxt_prog = step_val;
      end
   end

   always_comb begin
      w = (prog_q == len_q);
   end

   assign prog = prog_q;

`ifdef MOORE_DET_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // A clear coinciding with a new match leaves that match counted.
   always_ff @(posedge cl) begin
      if (r)
         cnt_q <= '0;
      else if (cnt_clr)
         cnt_q <= enter_match ? CNT_W'(1) : '0;
      else if (enter_match && cnt_q != '1)
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign match_cnt = cnt_q;
   assign unused_ok = hist_q[N-1];
`else
   assign match_cnt = '0;
   assign unused_ok = ^{cnt_clr, enter_match, hist_q[N-1]};
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Self-checking bench for moore_seq_detector against a queue-based stream model.
module tb_moore_seq_detector;

   localparam int N     = 6;
   localparam int LW    = $clog2(N+1);
   localparam int CNT_W = 2;
   localparam logic [N-1:0] PAT_INIT = 6'b101101;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MOORE_DET_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic             cl = 1'b0;
   logic             r, en, j, ovl, pat_ld, cnt_clr;
   logic [N-1:0]     pat_in;
   logic [LW-1:0]    len_in;
   logic             w;
   logic [LW-1:0]    prog;
   logic [CNT_W-1:0] match_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: effective stream as a queue, pattern, length, counter.
   bit         mq[$];
   bit [N-1:0] mpat;
   int         mlen, mprog, mcnt;

   always #5 cl = ~cl;

   moore_seq_detector #(.N(N), .PAT_INIT(PAT_INIT), .CNT_W(CNT_W)) dut (
      .cl(cl), .r(r), .en(en), .j(j), .ovl(ovl), .pat_ld(pat_ld),
      .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
      .w(w), .prog(prog), .match_cnt(match_cnt)
   );

   function automatic int longest_prefix();
      int best;
      bit ok;
      best = 0;
      for (int k = 1; k <= mlen; k++) begin
         if (k <= mq.size()) begin
            ok = 1'b1;
            for (int t = 0; t < k; t++)
               if (mpat[t] != mq[mq.size() - k + t]) ok = 1'b0;
            if (ok) best = k;
         end
      end
      return best;
   endfunction

   task automatic tick();
      bit inc;
      inc = 1'b0;
      if (r) begin
         mpat = PAT_INIT; mlen = N; mq.delete(); mprog = 0; mcnt = 0;
      end else begin
         if (pat_ld) begin
            mpat  = pat_in;
            mlen  = (len_in == 0) ? 1 : ((int'(len_in) > N) ? N : int'(len_in));
            mq.delete();
            mprog = 0;
         end else if (en) begin
            if (mprog == mlen && !ovl) mq.delete();
            mq.push_back(j);
            if (mq.size() > 40) void'(mq.pop_front());
            mprog = longest_prefix();
            inc   = (mprog == mlen);
         end
         if (CNT_EN) begin
            if (cnt_clr) mcnt = inc ? 1 : 0;
            else if (inc && mcnt < CNT_MAX) mcnt++;
         end
      end
      @(posedge cl);
      #1;
   endtask

   task automatic bit_in(input bit b);
      r = 1'b0; pat_ld = 1'b0; cnt_clr = 1'b0; en = 1'b1; j = b;
      tick();
   endtask

   task automatic idle();
      r = 1'b0; pat_ld = 1'b0; cnt_clr = 1'b0; en = 1'b0; j = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      r = 1'b1; pat_ld = 1'b0; cnt_clr = 1'b0; en = 1'b0; j = 1'b0;
      tick();
      r = 1'b0;
   endtask

   task automatic load(input logic [N-1:0] p, input logic [LW-1:0] l);
      r = 1'b0; pat_ld = 1'b1; pat_in = p; len_in = l; cnt_clr = 1'b0; en = 1'b0;
      tick();
      pat_ld = 1'b0;
   endtask

   task automatic test_reset();
      r = 1'b1; en = 1'b1; j = 1'b1; pat_ld = 1'b1; pat_in = '1; len_in = 2; cnt_clr = 1'b0;
      tick();
      r = 1'b0; pat_ld = 1'b0;
      checks++;
      if (prog !== '0 || w !== 1'b0 || match_cnt !== '0) begin
         errors++;
         $display("FAIL reset: prog=%0d w=%0b cnt=%0d, expected 0 0 0", prog, w, match_cnt);
      end
   endtask

   task automatic test_overlap();
      bit s[9] = '{1,0,1,1,0,1,1,0,1};
      do_reset();
      ovl = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bit_in(s[i]);
         checks++;
         if (prog !== LW'(mprog) || w !== (i == 5 || i == 8) || match_cnt !== CNT_W'(mcnt)) begin
            errors++;
            $display("FAIL overlap bit %0d: prog=%0d w=%0b cnt=%0d, expected prog=%0d w=%0b cnt=%0d",
                     i + 1, prog, w, match_cnt, mprog, (i == 5 || i == 8), mcnt);
         end
      end
      checks++;
      if (match_cnt !== CNT_W'(CNT_EN ? 2 : 0)) begin
         errors++;
         $display("FAIL overlap count: cnt=%0d, expected %0d", match_cnt, CNT_EN ? 2 : 0);
      end
   endtask

   task automatic test_nonoverlap();
      bit s[12] = '{1,0,1,1,0,1,1,0,1,1,0,1};
      do_reset();
      ovl = 1'b0;
      for (int i = 0; i < 12; i++) begin
         bit_in(s[i]);
         checks++;
         if (prog !== LW'(mprog) || w !== (i == 5 || i == 11) || match_cnt !== CNT_W'(mcnt)) begin
            errors++;
            $display("FAIL nonoverlap bit %0d: prog=%0d w=%0b cnt=%0d, expected prog=%0d w=%0b cnt=%0d",
                     i + 1, prog, w, match_cnt, mprog, (i == 5 || i == 11), mcnt);
         end
         if (i == 8) begin
            checks++;
            if (prog !== LW'(3)) begin
               errors++;
               $display("FAIL nonoverlap restart: prog=%0d, expected 3", prog);
            end
         end
      end
   endtask

   task automatic test_border();
      bit s[12] = '{1,0,1,1,0,0,1,0,1,1,0,1};
      int ep[12] = '{1,2,3,4,5,0,1,2,3,4,5,6};
      do_reset();
      ovl = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bit_in(s[i]);
         checks++;
         if (prog !== LW'(ep[i]) || prog !== LW'(mprog) || w !== (i == 11)) begin
            errors++;
            $display("FAIL border bit %0d: prog=%0d w=%0b, expected prog=%0d w=%0b",
                     i + 1, prog, w, ep[i], (i == 11));
         end
      end
   endtask

   task automatic test_stall();
      bit s[6] = '{1,0,1,1,0,1};
      for (int m = 0; m < 2; m++) begin
         do_reset();
         ovl = (m == 1);
         for (int i = 0; i < 6; i++) bit_in(s[i]);
         for (int c = 0; c < 3; c++) begin
            idle();
            checks++;
            if (w !== 1'b1 || prog !== LW'(6) || match_cnt !== CNT_W'(CNT_EN ? 1 : 0)) begin
               errors++;
               $display("FAIL stall ovl=%0d cycle %0d: w=%0b prog=%0d cnt=%0d, expected 1 6 %0d",
                        m, c, w, prog, match_cnt, CNT_EN ? 1 : 0);
            end
         end
         bit_in(1'b0);
         checks++;
         if (prog !== LW'(m == 1 ? 2 : 0) || w !== 1'b0 || match_cnt !== CNT_W'(mcnt)) begin
            errors++;
            $display("FAIL stall resume ovl=%0d: prog=%0d w=%0b cnt=%0d, expected %0d 0 %0d",
                     m, prog, w, match_cnt, m == 1 ? 2 : 0, mcnt);
         end
      end
   endtask

   task automatic test_load();
      bit ew3[3] = '{0,1,1};
      bit s4[4]  = '{0,1,0,0};
      bit ew4[4] = '{1,0,1,1};
      do_reset();
      ovl = 1'b1;
      r = 1'b0; pat_ld = 1'b1; pat_in = 6'b000011; len_in = 2; en = 1'b1; j = 1'b1; cnt_clr = 1'b0;
      tick();
      pat_ld = 1'b0;
      checks++;
      if (prog !== '0 || w !== 1'b0) begin
         errors++;
         $display("FAIL load edge: prog=%0d w=%0b, expected 0 0", prog, w);
      end
      for (int i = 0; i < 3; i++) begin
         bit_in(1'b1);
         checks++;
         if (w !== ew3[i] || prog !== LW'(mprog)) begin
            errors++;
            $display("FAIL load len2 bit %0d: w=%0b prog=%0d, expected w=%0b prog=%0d",
                     i + 1, w, prog, ew3[i], mprog);
         end
      end
      load(6'b111110, 0);
      ovl = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bit_in(s4[i]);
         checks++;
         if (w !== ew4[i] || prog !== LW'(ew4[i])) begin
            errors++;
            $display("FAIL load len0 bit %0d: w=%0b prog=%0d, expected %0b", i + 1, w, prog, ew4[i]);
         end
      end
      load(6'b111111, 7);
      for (int i = 0; i < 7; i++) begin
         bit_in(1'b1);
         checks++;
         if (w !== (i == 5) || prog !== LW'(mprog)) begin
            errors++;
            $display("FAIL load len7 bit %0d: w=%0b prog=%0d, expected w=%0b prog=%0d",
                     i + 1, w, prog, (i == 5), mprog);
         end
      end
   endtask

   task automatic test_counter_reset();
      bit s[6] = '{1,0,1,1,0,1};
      int ec;
      do_reset();
      ovl = 1'b1;
      load(6'b000001, 1);
      for (int i = 0; i < 5; i++) begin
         bit_in(1'b1);
         ec = CNT_EN ? ((i + 1 > CNT_MAX) ? CNT_MAX : i + 1) : 0;
         checks++;
         if (match_cnt !== CNT_W'(ec) || w !== 1'b1) begin
            errors++;
            $display("FAIL counter sat %0d: cnt=%0d w=%0b, expected %0d 1", i + 1, match_cnt, w, ec);
         end
      end
      cnt_clr = 1'b1; en = 1'b1; j = 1'b1;
      tick();
      cnt_clr = 1'b0;
      checks++;
      if (match_cnt !== CNT_W'(CNT_EN ? 1 : 0) || w !== 1'b1) begin
         errors++;
         $display("FAIL clear with match: cnt=%0d w=%0b, expected %0d 1", match_cnt, w, CNT_EN ? 1 : 0);
      end
      cnt_clr = 1'b1; en = 1'b0;
      tick();
      cnt_clr = 1'b0;
      checks++;
      if (match_cnt !== '0) begin
         errors++;
         $display("FAIL clear alone: cnt=%0d, expected 0", match_cnt);
      end
      bit_in(1'b1);
      r = 1'b1; en = 1'b1; j = 1'b1;
      tick();
      r = 1'b0;
      checks++;
      if (prog !== '0 || w !== 1'b0 || match_cnt !== '0) begin
         errors++;
         $display("FAIL reset mid-match: prog=%0d w=%0b cnt=%0d, expected 0 0 0", prog, w, match_cnt);
      end
      for (int i = 0; i < 6; i++) begin
         bit_in(s[i]);
         checks++;
         if (prog !== LW'(i + 1) || w !== (i == 5)) begin
            errors++;
            $display("FAIL reverted pattern bit %0d: prog=%0d w=%0b, expected %0d %0b",
                     i + 1, prog, w, i + 1, (i == 5));
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      ovl = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         r       = ($urandom_range(0, 249) == 0);
         pat_ld  = ($urandom_range(0, 39) == 0);
         pat_in  = N'($urandom);
         len_in  = LW'($urandom_range(0, 7));
         en      = ($urandom_range(0, 3) != 0);
         cnt_clr = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 15) == 0) ovl = ~ovl;
         if (mprog < mlen && $urandom_range(0, 3) != 0) j = mpat[mprog];
         else j = $urandom_range(0, 1);
         tick();
         checks++;
         if (prog !== LW'(mprog) || w !== (mprog == mlen) || match_cnt !== CNT_W'(mcnt)) begin
            errors++;
            $display("FAIL random cycle %0d: prog=%0d w=%0b cnt=%0d, expected prog=%0d w=%0b cnt=%0d",
                     c, prog, w, match_cnt, mprog, (mprog == mlen), mcnt);
         end
      end
      r = 1'b0; pat_ld = 1'b0; cnt_clr = 1'b0;
   endtask

   initial begin
      r = 1'b0; en = 1'b0; j = 1'b0; ovl = 1'b1; pat_ld = 1'b0; cnt_clr = 1'b0;
      pat_in = '0; len_in = '0;
      mpat = PAT_INIT; mlen = N; mprog = 0; mcnt = 0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_border();
      test_stall();
      test_load();
      test_counter_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
